// File: rtl/dp_pingpong_reg_if.sv
// Bus bundle for the double-buffered register bank: write port, swap
// control, read port and the visible bank state.
interface dp_pingpong_reg_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             ld;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] a;
  logic             swap;
  logic             keep;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             dirty;

  // Producer/consumer side: drives strobes and addresses, observes state.
  modport master (
    output ld, wr_addr, a, swap, keep, rd_addr,
    input  b, sel, dirty
  );

  // Register bank side.
  modport slave (
    input  ld, wr_addr, a, swap, keep, rd_addr,
    output b, sel, dirty
  );
endinterface

// File: rtl/dp_pingpong_reg.sv
// Double-buffered register bank. Writers fill the back bank, readers see the
// front bank through a registered read port, and an accepted swap exchanges
// the roles of the two banks in a single edge. Optional copy mode mirrors
// the new front into the new back so later partial updates start from a
// consistent frame.
module dp_pingpong_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic clk,
  input logic clr,
  dp_pingpong_reg_if.slave bus
);

  // DEPTH as an AW+1 bit value so addresses compare unsigned without
  // truncation, even when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] bank0 [DEPTH];
  logic [WIDTH-1:0] bank1 [DEPTH];
  logic [WIDTH-1:0] back_wr [DEPTH];
  logic [WIDTH-1:0] front_word;
  logic [WIDTH-1:0] rd_data;
  logic             front_sel;
  logic             dirty_flag;
  logic             wr_ok;
  logic             rd_ok;
  logic             accept;
  logic [AW-1:0]    rd_idx;

  // Decode the strobes and build the back bank as it looks after this
  // edge's write; that image feeds both the back bank and the keep copy.
  always_comb begin
    wr_ok  = bus.ld && ({1'b0, bus.wr_addr} < DEPTH_L);
    rd_ok  = {1'b0, bus.rd_addr} < DEPTH_L;
    accept = bus.swap && (dirty_flag || wr_ok);
    rd_idx = rd_ok ? bus.rd_addr : '0;
    for (int i = 0; i < DEPTH; i++) begin
      back_wr[i] = front_sel ? bank0[i] : bank1[i];
      if (wr_ok && (bus.wr_addr == AW'(i))) begin
        back_wr[i] = bus.a;
      end
    end
    front_word = '0;
    if (rd_ok) begin
      front_word = front_sel ? bank1[rd_idx] : bank0[rd_idx];
    end
  end

  // Bank contents, read register, front index and dirty flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      rd_data    <= '0;
      front_sel  <= 1'b0;
      dirty_flag <= 1'b0;
    end else begin
      // Read uses the front selected before this edge.
      rd_data <= front_word;
      // The back bank always takes the written image; the front bank takes
      // it only when a copy-mode swap makes it the new back.
      for (int i = 0; i < DEPTH; i++) begin
        if (front_sel || (accept && bus.keep)) begin
          bank0[i] <= back_wr[i];
        end
        if (!front_sel || (accept && bus.keep)) begin
          bank1[i] <= back_wr[i];
        end
      end
      if (accept) begin
        front_sel  <= ~front_sel;
        dirty_flag <= 1'b0;
      end else if (wr_ok) begin
        dirty_flag <= 1'b1;
      end
    end
  end

  assign bus.b     = rd_data;
  assign bus.sel   = front_sel;
  assign bus.dirty = dirty_flag;

endmodule
